// File: rtl/demux_stream_pkg.sv
// Shared constants and types for the select-driven stream demultiplexer.
// Broadcast build option: DEMUX_STREAM_ROUTE_BROADCAST_EN.
package demux_stream_pkg;

  localparam int SEL_W       = 4;
  localparam int MAX_OUTPUTS = 16;
  localparam int DROP_W      = 16;

  localparam logic [SEL_W-1:0] BCAST_SEL = 4'hF;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_e;

  function automatic logic [DROP_W-1:0] sat_inc(
    input logic [DROP_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry registered holding slot with valid/ready output handshake.
// Accepts a refill in the same cycle its current sample is consumed.
module demux_slot
  import demux_stream_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              can_take,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data
);

  slot_state_e       state_q;
  slot_state_e       state_d;
  logic [DWIDTH-1:0] data_q;
  logic              wr_ok;

  // a write is honoured only when the slot has room, so held data is stable
  assign wr_ok = wr_en & can_take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SLOT_EMPTY: begin
        if (wr_ok) state_d = SLOT_FULL;
      end
      SLOT_FULL: begin
        if (wr_ok) state_d = SLOT_FULL;
        else if (out_ready) state_d = SLOT_EMPTY;
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == SLOT_FULL);
    can_take  = (state_q == SLOT_EMPTY) | out_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (wr_ok) begin
      data_q <= wr_data;
    end
  end

  assign out_data = data_q;

endmodule

// File: rtl/demux_stream_route.sv
// Routes one sample stream to OUTPUTS holding slots by integer select.
// Build option DEMUX_STREAM_ROUTE_BROADCAST_EN makes select 4'hF a broadcast.
module demux_stream_route
  import demux_stream_pkg::*;
#(
  parameter int OUTPUTS = 8,
  parameter int DWIDTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_select,
  input  logic [DWIDTH-1:0] in_data,
  output logic [OUTPUTS-1:0] out_valid,
  input  logic [OUTPUTS-1:0] out_ready,
  output logic [DWIDTH-1:0] out_data [OUTPUTS],
  output logic [DROP_W-1:0] drop_count
);

  localparam logic [SEL_W:0] N_OUT = (SEL_W+1)'(OUTPUTS);

  logic [OUTPUTS-1:0]     can_take;
  logic [OUTPUTS-1:0]     wr_en;
  logic [MAX_OUTPUTS-1:0] take_pad;
  logic                   is_bcast;
  logic                   in_range;
  logic                   is_drop;
  logic                   xfer;
  logic [DROP_W-1:0]      drop_q;

  always_comb begin
    take_pad              = '0;
    take_pad[OUTPUTS-1:0] = can_take;
  end

`ifdef DEMUX_STREAM_ROUTE_BROADCAST_EN
  assign is_bcast = (in_select == BCAST_SEL);
`else
  assign is_bcast = 1'b0;
`endif

  assign in_range = ({1'b0, in_select} < N_OUT) & ~is_bcast;

  // decode classes are exclusive: broadcast, single slot, or drop
  always_comb begin
    in_ready = 1'b1;
    is_drop  = 1'b0;
    unique case (1'b1)
      is_bcast: in_ready = &can_take;
      in_range: in_ready = take_pad[in_select];
      default:  is_drop  = 1'b1;
    endcase
  end

  assign xfer = in_valid & in_ready;

  for (genvar k = 0; k < OUTPUTS; k++) begin : g_slot
    assign wr_en[k] = xfer &
      (is_bcast | (in_range & (in_select == SEL_W'(k))));

    demux_slot #(
      .DWIDTH (DWIDTH)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en[k]),
      .wr_data   (in_data),
      .can_take  (can_take[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_data  (out_data[k])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= '0;
    end else if (xfer & is_drop) begin
      drop_q <= sat_inc(drop_q);
    end
  end

  assign drop_count = drop_q;

endmodule

// File: tb/tb_demux_stream_route.sv
// Randomized and directed bench for demux_stream_route (OUTPUTS=8).
// Reference model tracks per-channel occupancy, data and drops.
module tb_demux_stream_route;

  localparam int N = 8;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_select = '0;
  logic [W-1:0] in_data = '0;
  logic [N-1:0] out_valid;
  logic [N-1:0] out_ready = '0;
  logic [W-1:0] out_data [N];
  logic [15:0]  drop_count;

  int total = 0;
  int bad = 0;

  bit           m_valid [N];
  logic [W-1:0] m_data [N];
  int           m_drops;
  logic         last_ready;

  always #5 clk = ~clk;

  demux_stream_route #(
    .OUTPUTS (N),
    .DWIDTH  (W)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_select  (in_select),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .drop_count (drop_count)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_bcast(input logic [3:0] s);
`ifdef DEMUX_STREAM_ROUTE_BROADCAST_EN
    return s == 4'hF;
`else
    return (s == 4'hF) && 1'b0;
`endif
  endfunction

  function automatic bit m_ready(input logic [3:0] s,
                                 input logic [N-1:0] rdy);
    int idx;
    idx = int'(s);
    if (m_bcast(s)) begin
      for (int k = 0; k < N; k++)
        if (m_valid[k] && !rdy[k]) return 1'b0;
      return 1'b1;
    end
    if (idx < N) return !m_valid[idx] || rdy[idx];
    return 1'b1;
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < N; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = '0;
    end
    m_drops = 0;
  endfunction

  task automatic m_edge();
    bit go;
    int idx;
    go  = in_valid && m_ready(in_select, out_ready);
    idx = int'(in_select);
    for (int k = 0; k < N; k++)
      if (m_valid[k] && out_ready[k]) m_valid[k] = 1'b0;
    if (go) begin
      if (m_bcast(in_select)) begin
        for (int k = 0; k < N; k++) begin
          m_valid[k] = 1'b1;
          m_data[k]  = in_data;
        end
      end else if (idx < N) begin
        m_valid[idx] = 1'b1;
        m_data[idx]  = in_data;
      end else if (m_drops < 65535) begin
        m_drops++;
      end
    end
  endtask

  task automatic check_outs();
    logic [N-1:0] ev;
    for (int k = 0; k < N; k++) ev[k] = m_valid[k];
    check("out_valid", 32'(out_valid), 32'(ev));
    for (int k = 0; k < N; k++)
      check($sformatf("out_data%0d", k), 32'(out_data[k]),
            32'(m_data[k]));
    check("drop_count", 32'(drop_count), 32'(m_drops));
  endtask

  // starts and ends on a falling edge
  task automatic cycle(input logic v, input logic [3:0] sel,
                       input logic [W-1:0] d, input logic [N-1:0] rdy);
    in_valid  = v;
    in_select = sel;
    in_data   = d;
    out_ready = rdy;
    #1;
    last_ready = in_ready;
    check("in_ready", 32'(in_ready), 32'(m_ready(sel, rdy)));
    @(posedge clk);
    m_edge();
    #1;
    check_outs();
    @(negedge clk);
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    check_outs();
    reset = 1'b0;

    cycle(1'b1, 4'd3, 16'h1234, '0);
    check("route_valid", 32'(out_valid), 32'h08);
    check("route_data", 32'(out_data[3]), 32'h1234);
    cycle(1'b1, 4'd3, 16'h5555, '0);
    check("route_busy", 32'(last_ready), 32'h0);

    cycle(1'b1, 4'd2, 16'h00AA, '0);
    cycle(1'b1, 4'd2, 16'h00BB, 8'h04);
    check("refill_ready", 32'(last_ready), 32'h1);
    check("refill_data", 32'(out_data[2]), 32'h00BB);
    check("refill_valid", 32'(out_valid[2]), 32'h1);

    cycle(1'b1, 4'd5, 16'h5A5A, '0);
    cycle(1'b1, 4'd0, 16'h0100, '0);
    check("indep_rdy0", 32'(last_ready), 32'h1);
    cycle(1'b1, 4'd1, 16'h0101, '0);
    check("indep_rdy1", 32'(last_ready), 32'h1);
    cycle(1'b1, 4'd6, 16'h0106, '0);
    check("indep_rdy6", 32'(last_ready), 32'h1);
    check("indep_hold5", 32'(out_data[5]), 32'h5A5A);

    for (int i = 0; i < 3; i++)
      cycle(1'b1, 4'd9, 16'($urandom), '0);
    check("drop_three", 32'(drop_count), 32'h3);

    force u_dut.drop_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release u_dut.drop_q;
    m_drops = 65534;
    @(negedge clk);
    cycle(1'b0, 4'd0, '0, '0);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 4'd9, 16'($urandom), '0);
    check("drop_sat", 32'(drop_count), 32'hFFFF);

    reset = 1'b1;
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 7; i++)
      cycle(1'b1, 4'd12, 16'($urandom), '0);
    cycle(1'b1, 4'd0, 16'hC000, '0);
    cycle(1'b1, 4'd4, 16'hC004, '0);
    check("pre_rst_valid", 32'(out_valid), 32'h11);
    check("pre_rst_drops", 32'(drop_count), 32'h7);
    #2 reset = 1'b1;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'h0);
    check("rst_async_drops", 32'(drop_count), 32'h0);
    m_reset();
    @(negedge clk);
    reset = 1'b0;

`ifdef DEMUX_STREAM_ROUTE_BROADCAST_EN
    cycle(1'b1, 4'd1, 16'h1111, '0);
    cycle(1'b1, 4'hF, 16'h0F0F, '0);
    check("bcast_stall", 32'(last_ready), 32'h0);
    cycle(1'b1, 4'hF, 16'h0F0F, 8'h02);
    check("bcast_ready", 32'(last_ready), 32'h1);
    check("bcast_valid", 32'(out_valid), 32'hFF);
    for (int k = 0; k < N; k++)
      check($sformatf("bcast_data%0d", k), 32'(out_data[k]),
            32'h0F0F);
    cycle(1'b0, 4'd0, '0, '1);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [3:0] s;
      if ($urandom_range(0, 3) == 0)
        s = 4'($urandom_range(8, 15));
      else
        s = 4'($urandom_range(0, 7));
      cycle($urandom_range(0, 3) != 0, s, 16'($urandom),
            8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
